// File: rtl/complex_trunc_arb_if.sv
// rtl/complex_trunc_arb_if.sv - stream handshake bundle (tdata/tvalid/tready/tlast)
interface complex_trunc_arb_if #(
    parameter int W = 82
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/complex_trunc_arb.sv
// rtl/complex_trunc_arb.sv - two-input packet round-robin arbiter with saturating complex MSB truncation
module complex_trunc_arb #(
    parameter int WIDTH_IN  = 41,
    parameter int WIDTH_OUT = 16,
    parameter int MAX_SHIFT = 8,
    parameter int SHIFT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    complex_trunc_arb_if.slave        s0,
    complex_trunc_arb_if.slave        s1,
    input  logic [SHIFT_W-1:0]        shift0,
    input  logic [SHIFT_W-1:0]        shift1,
    complex_trunc_arb_if.master       m,
    output logic                      m_tid,
    output logic                      sat
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rr_last;
    logic [SHIFT_W-1:0]      shift_r;
    logic [1:0]              rst_sync;
    logic                    soft_rst;

    logic                    out_free;
    logic                    acc0;
    logic                    acc1;
    logic                    acc;
    logic [2*WIDTH_IN-1:0]   sel_data;
    logic                    sel_last;
    logic [WIDTH_OUT-1:0]    i_out;
    logic [WIDTH_OUT-1:0]    q_out;
    logic                    i_sat;
    logic                    q_sat;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : s;
    endfunction

    // Returns {saturated, value}; saturates when the s+1 top bits disagree.
    function automatic logic [WIDTH_OUT:0] trunc_sat(input logic [WIDTH_IN-1:0] x,
                                                     input logic [SHIFT_W-1:0]  s);
        logic [WIDTH_IN-1:0]  shifted;
        logic [WIDTH_OUT-1:0] val;
        logic                 ovf;
        shifted = x << s;
        val     = shifted[WIDTH_IN-1 -: WIDTH_OUT];
        ovf     = 1'b0;
        for (int i = 1; i <= MAX_SHIFT; i++) begin
            if (i <= int'(s) && x[WIDTH_IN-1-i] != x[WIDTH_IN-1]) begin
                ovf = 1'b1;
            end
        end
        if (ovf) begin
            val = x[WIDTH_IN-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                : {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end
        return {ovf, val};
    endfunction

    // Release of reset_n is retimed; until it propagates the core is held as if cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign soft_rst = clear || !rst_sync[1];

    assign out_free  = !m.tvalid || m.tready;
    assign s0.tready = (state == GRANT0) && out_free;
    assign s1.tready = (state == GRANT1) && out_free;
    assign acc0      = s0.tvalid && s0.tready;
    assign acc1      = s1.tvalid && s1.tready;
    assign acc       = acc0 || acc1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0.tvalid && (!s1.tvalid || rr_last)) begin
                    state_nxt = GRANT0;
                end else if (s1.tvalid) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (acc0 && s0.tlast) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (acc1 && s1.tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            shift_r <= '0;
        end else if (soft_rst) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            shift_r <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT0) begin
                shift_r <= clamp_shift(shift0);
            end else if (state == IDLE && state_nxt == GRANT1) begin
                shift_r <= clamp_shift(shift1);
            end
            if (acc0 && s0.tlast) begin
                rr_last <= 1'b0;
            end else if (acc1 && s1.tlast) begin
                rr_last <= 1'b1;
            end
        end
    end

    assign sel_data = (state == GRANT1) ? s1.tdata : s0.tdata;
    assign sel_last = (state == GRANT1) ? s1.tlast : s0.tlast;

    assign {i_sat, i_out} = trunc_sat(sel_data[2*WIDTH_IN-1:WIDTH_IN], shift_r);
    assign {q_sat, q_out} = trunc_sat(sel_data[WIDTH_IN-1:0], shift_r);

    // sat is a single-cycle pulse on the first cycle a saturated beat is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
            m.tdata  <= '0;
            m_tid    <= 1'b0;
            sat      <= 1'b0;
        end else if (soft_rst) begin
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
            m.tdata  <= '0;
            m_tid    <= 1'b0;
            sat      <= 1'b0;
        end else if (acc) begin
            m.tvalid <= 1'b1;
            m.tlast  <= sel_last;
            m.tdata  <= {i_out, q_out};
            m_tid    <= acc1;
            sat      <= i_sat || q_sat;
        end else begin
            sat <= 1'b0;
            if (m.tready) begin
                m.tvalid <= 1'b0;
            end
        end
    end

endmodule
